// File: rtl/bus_wrap_if.sv
// Bundled bus-in / stream-out / stream-in / bus-out signals of the bus_wrap link adapter.
// slave is the adapter's view, master is the view of whatever drives it.
interface bus_wrap_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int SW = 8
);
    logic          bsi_vld;
    logic [AW-1:0] bsi_adr;
    logic [DW-1:0] bsi_dat;
    logic          bsi_rdy;
    logic          sto_vld;
    logic [SW-1:0] sto_bus;
    logic          sto_rdy;
    logic          sti_vld;
    logic [SW-1:0] sti_bus;
    logic          sti_rdy;
    logic          bso_vld;
    logic [AW-1:0] bso_adr;
    logic [DW-1:0] bso_dat;
    logic          bso_rdy;

    modport slave (
        input  bsi_vld, bsi_adr, bsi_dat, sto_rdy, sti_vld, sti_bus, bso_rdy,
        output bsi_rdy, sto_vld, sto_bus, sti_rdy, bso_vld, bso_adr, bso_dat
    );

    modport master (
        output bsi_vld, bsi_adr, bsi_dat, sto_rdy, sti_vld, sti_bus, bso_rdy,
        input  bsi_rdy, sto_vld, sto_bus, sti_rdy, bso_vld, bso_adr, bso_dat
    );
endinterface

// File: rtl/bus_wrap.sv
// Link adapter: serializes bus writes into byte frames (address LSB first, then data) and
// reassembles incoming frames into bus writes. BUS_WRAP_CHECKSUM_EN adds a trailing XOR byte.
module bus_wrap #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int SW = 8
) (
    input  logic      clk,
    input  logic      rst,
    bus_wrap_if.slave bus
);
    localparam int N  = (AW + DW) / SW;
`ifdef BUS_WRAP_CHECKSUM_EN
    localparam int NB = N + 1;
`else
    localparam int NB = N;
`endif
    localparam int FW = NB * SW;
    localparam int CW = $clog2(NB + 1);

    typedef enum logic {SER_IDLE = 1'b0, SER_SEND = 1'b1} ser_st_e;
    typedef enum logic {DES_COLLECT = 1'b0, DES_HOLD = 1'b1} des_st_e;

`ifdef BUS_WRAP_CHECKSUM_EN
    function automatic logic [SW-1:0] xor_bytes(input logic [AW+DW-1:0] v);
        logic [SW-1:0] acc;
        acc = {SW{1'b0}};
        for (int i = 0; i < N; i++) begin
            acc = acc ^ v[i*SW +: SW];
        end
        return acc;
    endfunction
`endif

    ser_st_e       ser_st_q, ser_st_d;
    logic [FW-1:0] ser_sr_q, ser_sr_d;
    logic [CW-1:0] ser_cnt_q, ser_cnt_d;
    logic          bsi_rdy_q, bsi_rdy_d;
    logic          sto_vld_q, sto_vld_d;
    logic [FW-1:0] frame_s;
    logic          bsi_xfer_s, sto_xfer_s;

    des_st_e          des_st_q, des_st_d;
    logic [FW-SW-1:0] des_sr_q, des_sr_d;
    logic [CW-1:0]    des_cnt_q, des_cnt_d;
    logic             sti_rdy_q, sti_rdy_d;
    logic             bso_vld_q, bso_vld_d;
    logic [AW-1:0]    bso_adr_q, bso_adr_d;
    logic [DW-1:0]    bso_dat_q, bso_dat_d;
    logic [FW-1:0]    des_full_s;
    logic             sti_xfer_s, bso_xfer_s, des_last_s, des_ok_s;

    assign bsi_xfer_s = bus.bsi_vld & bsi_rdy_q;
    assign sto_xfer_s = sto_vld_q & bus.sto_rdy;
    assign sti_xfer_s = bus.sti_vld & sti_rdy_q;
    assign bso_xfer_s = bso_vld_q & bus.bso_rdy;
    // Newest byte enters at the top so the first byte of a frame ends up at bit 0.
    assign des_full_s = {bus.sti_bus, des_sr_q};
    assign des_last_s = sti_xfer_s && (des_cnt_q == CW'(NB - 1));

`ifdef BUS_WRAP_CHECKSUM_EN
    assign frame_s  = {xor_bytes({bus.bsi_dat, bus.bsi_adr}), bus.bsi_dat, bus.bsi_adr};
    assign des_ok_s = (xor_bytes(des_full_s[AW+DW-1:0]) == des_full_s[FW-1:AW+DW]);
`else
    assign frame_s  = {bus.bsi_dat, bus.bsi_adr};
    assign des_ok_s = 1'b1;
`endif

    assign bus.bsi_rdy = bsi_rdy_q;
    assign bus.sto_vld = sto_vld_q;
    assign bus.sto_bus = ser_sr_q[SW-1:0];
    assign bus.sti_rdy = sti_rdy_q;
    assign bus.bso_vld = bso_vld_q;
    assign bus.bso_adr = bso_adr_q;
    assign bus.bso_dat = bso_dat_q;

    // Serializer state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ser_st_q  <= SER_IDLE;
            ser_sr_q  <= {FW{1'b0}};
            ser_cnt_q <= {CW{1'b0}};
            bsi_rdy_q <= 1'b0;
            sto_vld_q <= 1'b0;
        end else begin
            ser_st_q  <= ser_st_d;
            ser_sr_q  <= ser_sr_d;
            ser_cnt_q <= ser_cnt_d;
            bsi_rdy_q <= bsi_rdy_d;
            sto_vld_q <= sto_vld_d;
        end
    end

    // Serializer next state
    always_comb begin
        ser_st_d = ser_st_q;
        case (ser_st_q)
            SER_IDLE: begin
                if (bsi_xfer_s) ser_st_d = SER_SEND;
                else            ser_st_d = SER_IDLE;
            end
            SER_SEND: begin
                if (sto_xfer_s && (ser_cnt_q == CW'(1))) ser_st_d = SER_IDLE;
                else                                      ser_st_d = SER_SEND;
            end
            default: ser_st_d = SER_IDLE;
        endcase
    end

    // Serializer shift register, byte counter and registered handshakes
    always_comb begin
        ser_sr_d  = ser_sr_q;
        ser_cnt_d = ser_cnt_q;
        if (bsi_xfer_s) begin
            ser_sr_d  = frame_s;
            ser_cnt_d = CW'(NB);
        end else if (sto_xfer_s) begin
            ser_sr_d  = {{SW{1'b0}}, ser_sr_q[FW-1:SW]};
            ser_cnt_d = ser_cnt_q - CW'(1);
        end else begin
            ser_sr_d  = ser_sr_q;
            ser_cnt_d = ser_cnt_q;
        end
        bsi_rdy_d = (ser_st_d == SER_IDLE);
        sto_vld_d = (ser_st_d == SER_SEND);
    end

    // Deserializer state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            des_st_q  <= DES_COLLECT;
            des_sr_q  <= {(FW-SW){1'b0}};
            des_cnt_q <= {CW{1'b0}};
            sti_rdy_q <= 1'b0;
            bso_vld_q <= 1'b0;
            bso_adr_q <= {AW{1'b0}};
            bso_dat_q <= {DW{1'b0}};
        end else begin
            des_st_q  <= des_st_d;
            des_sr_q  <= des_sr_d;
            des_cnt_q <= des_cnt_d;
            sti_rdy_q <= sti_rdy_d;
            bso_vld_q <= bso_vld_d;
            bso_adr_q <= bso_adr_d;
            bso_dat_q <= bso_dat_d;
        end
    end

    // Deserializer next state; a bad check byte keeps it collecting
    always_comb begin
        des_st_d = des_st_q;
        case (des_st_q)
            DES_COLLECT: begin
                if (des_last_s && des_ok_s) des_st_d = DES_HOLD;
                else                        des_st_d = DES_COLLECT;
            end
            DES_HOLD: begin
                if (bso_xfer_s) des_st_d = DES_COLLECT;
                else            des_st_d = DES_HOLD;
            end
            default: des_st_d = DES_COLLECT;
        endcase
    end

    // Deserializer assembly, counter and bus-out registers
    always_comb begin
        des_sr_d  = des_sr_q;
        des_cnt_d = des_cnt_q;
        bso_vld_d = bso_vld_q;
        bso_adr_d = bso_adr_q;
        bso_dat_d = bso_dat_q;
        if (des_last_s) begin
            des_sr_d  = des_full_s[FW-1:SW];
            des_cnt_d = {CW{1'b0}};
            if (des_ok_s) begin
                bso_vld_d = 1'b1;
                bso_adr_d = des_full_s[AW-1:0];
                bso_dat_d = des_full_s[AW+DW-1:AW];
            end else begin
                bso_vld_d = bso_vld_q;
            end
        end else if (sti_xfer_s) begin
            des_sr_d  = des_full_s[FW-1:SW];
            des_cnt_d = des_cnt_q + CW'(1);
        end else if (bso_xfer_s) begin
            bso_vld_d = 1'b0;
        end else begin
            bso_vld_d = bso_vld_q;
        end
        sti_rdy_d = (des_st_d == DES_COLLECT);
    end
endmodule

// File: tb/tb_bus_wrap.sv
// Directed self-checking bench for bus_wrap: reset, single frame, stall, backpressure, loopback, checksum.
module tb_bus_wrap;
`ifdef BUS_WRAP_CHECKSUM_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic clk;
    logic rst;
    logic loop_en_r, corrupt_en_r;
    logic tb_sti_vld_r, tb_sto_rdy_r;
    logic [7:0] tb_sti_bus_r;
    int lb_cnt_r;
    int test_cnt, fail_cnt;
    logic [63:0] rx_q [$];
    logic [63:0] exp_q [$];
    logic [7:0] exp_b [0:8];

    bus_wrap_if u_if ();

    bus_wrap u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stream side: loopback (with optional corruption of frame byte 2) or direct drive
    always_comb begin
        if (loop_en_r) begin
            u_if.sti_vld = u_if.sto_vld;
            u_if.sti_bus = u_if.sto_bus ^ ((corrupt_en_r && lb_cnt_r == 2) ? 8'h40 : 8'h00);
            u_if.sto_rdy = u_if.sti_rdy;
        end else begin
            u_if.sti_vld = tb_sti_vld_r;
            u_if.sti_bus = tb_sti_bus_r;
            u_if.sto_rdy = tb_sto_rdy_r;
        end
    end

    // Byte position within the outgoing frame
    always @(posedge clk or negedge rst) begin
        if (!rst) lb_cnt_r <= 0;
        else if (u_if.sto_vld && u_if.sto_rdy) lb_cnt_r <= (lb_cnt_r == NB - 1) ? 0 : lb_cnt_r + 1;
    end

    // Record every completed bus-out transfer
    always @(negedge clk) begin
        if (rst && u_if.bso_vld && u_if.bso_rdy) rx_q.push_back({u_if.bso_adr, u_if.bso_dat});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        test_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bsi_write(input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        u_if.bsi_vld = 1'b1;
        u_if.bsi_adr = a;
        u_if.bsi_dat = d;
        while (!u_if.bsi_rdy && n < 200) begin
            tick();
            n++;
        end
        check_val("bsi_rdy_wait", 64'(n < 200), 64'd1);
        tick();
        u_if.bsi_vld = 1'b0;
    endtask

    // Walk the serializer output through exp_b, optionally stalling 5 cycles on one byte
    task automatic stream_check(input string tag, input int stall_at);
`ifdef BUS_WRAP_CHECKSUM_EN
        exp_b[8] = 8'h00;
        for (int i = 0; i < 8; i++) exp_b[8] = exp_b[8] ^ exp_b[i];
`endif
        for (int i = 0; i < NB; i++) begin
            if (i == stall_at) begin
                tb_sto_rdy_r = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    check_val({tag, "_stall_vld"}, 64'(u_if.sto_vld), 64'd1);
                    check_val({tag, "_stall_bus"}, 64'(u_if.sto_bus), 64'(exp_b[i]));
                end
                tb_sto_rdy_r = 1'b1;
            end
            check_val({tag, "_vld"}, 64'(u_if.sto_vld), 64'd1);
            check_val({tag, "_byte"}, 64'(u_if.sto_bus), 64'(exp_b[i]));
            check_val({tag, "_bsi_rdy"}, 64'(u_if.bsi_rdy), 64'd0);
            tick();
        end
        check_val({tag, "_end_vld"}, 64'(u_if.sto_vld), 64'd0);
        check_val({tag, "_end_bsi_rdy"}, 64'(u_if.bsi_rdy), 64'd1);
    endtask

    // Feed one frame directly into the deserializer, one byte per accepted cycle
    task automatic send_sti_frame(input logic [31:0] a, input logic [31:0] d);
        logic [7:0] b [0:8];
        int n;
        for (int i = 0; i < 4; i++) begin
            b[i]     = a[8*i +: 8];
            b[4 + i] = d[8*i +: 8];
        end
        b[8] = 8'h00;
        for (int i = 0; i < 8; i++) b[8] = b[8] ^ b[i];
        for (int i = 0; i < NB; i++) begin
            tb_sti_vld_r = 1'b1;
            tb_sti_bus_r = b[i];
            n = 0;
            while (!u_if.sti_rdy && n < 200) begin
                tick();
                n++;
            end
            if (n >= 200) check_val("sti_rdy_wait", 64'(n), 64'd0);
            tick();
        end
        tb_sti_vld_r = 1'b0;
    endtask

    initial begin
        test_cnt = 0;
        fail_cnt = 0;
        rst = 1'b0;
        loop_en_r = 1'b0;
        corrupt_en_r = 1'b0;
        tb_sti_vld_r = 1'b0;
        tb_sti_bus_r = 8'h00;
        tb_sto_rdy_r = 1'b1;
        u_if.bsi_vld = 1'b0;
        u_if.bsi_adr = 32'h0;
        u_if.bsi_dat = 32'h0;
        u_if.bso_rdy = 1'b0;

        // Reset held for 4 cycles
        for (int c = 0; c < 4; c++) begin
            tick();
            check_val("rst_bsi_rdy", 64'(u_if.bsi_rdy), 64'd0);
            check_val("rst_sti_rdy", 64'(u_if.sti_rdy), 64'd0);
        end
        check_val("rst_sto_vld", 64'(u_if.sto_vld), 64'd0);
        check_val("rst_sto_bus", 64'(u_if.sto_bus), 64'd0);
        check_val("rst_bso_vld", 64'(u_if.bso_vld), 64'd0);
        check_val("rst_bso_adr", 64'(u_if.bso_adr), 64'd0);
        check_val("rst_bso_dat", 64'(u_if.bso_dat), 64'd0);
        rst = 1'b1;
        tick();
        check_val("rel_bsi_rdy", 64'(u_if.bsi_rdy), 64'd1);
        check_val("rel_sti_rdy", 64'(u_if.sti_rdy), 64'd1);

        // Single frame
        bsi_write(32'h0000_0003, 32'h1234_5678);
        exp_b[0] = 8'h03; exp_b[1] = 8'h00; exp_b[2] = 8'h00; exp_b[3] = 8'h00;
        exp_b[4] = 8'h78; exp_b[5] = 8'h56; exp_b[6] = 8'h34; exp_b[7] = 8'h12;
        stream_check("single", -1);

        // Stall in the middle of byte 4
        bsi_write(32'hA1B2_C3D4, 32'h0F1E_2D3C);
        exp_b[0] = 8'hD4; exp_b[1] = 8'hC3; exp_b[2] = 8'hB2; exp_b[3] = 8'hA1;
        exp_b[4] = 8'h3C; exp_b[5] = 8'h2D; exp_b[6] = 8'h1E; exp_b[7] = 8'h0F;
        stream_check("stall", 3);

        // Output backpressure
        rx_q.delete();
        u_if.bso_rdy = 1'b0;
        send_sti_frame(32'h0000_0055, 32'hCAFE_F00D);
        tb_sti_vld_r = 1'b1;
        tb_sti_bus_r = 8'hEE;
        check_val("bp_bso_vld", 64'(u_if.bso_vld), 64'd1);
        check_val("bp_bso_adr", 64'(u_if.bso_adr), 64'h55);
        check_val("bp_bso_dat", 64'(u_if.bso_dat), 64'hCAFE_F00D);
        check_val("bp_sti_rdy", 64'(u_if.sti_rdy), 64'd0);
        repeat (3) tick();
        check_val("bp_hold_vld", 64'(u_if.bso_vld), 64'd1);
        check_val("bp_hold_sti_rdy", 64'(u_if.sti_rdy), 64'd0);
        check_val("bp_hold_adr", 64'(u_if.bso_adr), 64'h55);
        u_if.bso_rdy = 1'b1;
        tb_sti_vld_r = 1'b0;
        tick();
        u_if.bso_rdy = 1'b0;
        check_val("bp_done_vld", 64'(u_if.bso_vld), 64'd0);
        check_val("bp_done_sti_rdy", 64'(u_if.sti_rdy), 64'd1);
        check_val("bp_keep_dat", 64'(u_if.bso_dat), 64'hCAFE_F00D);
        check_val("bp_xfer_cnt", 64'(rx_q.size()), 64'd1);
        u_if.bso_rdy = 1'b1;
        send_sti_frame(32'h0000_0066, 32'h0102_0304);
        check_val("bp_next_vld", 64'(u_if.bso_vld), 64'd1);
        check_val("bp_next_adr", 64'(u_if.bso_adr), 64'h66);
        check_val("bp_next_dat", 64'(u_if.bso_dat), 64'h0102_0304);
        tick();

        // Loopback burst of 10 writes
        rx_q.delete();
        exp_q.delete();
        loop_en_r = 1'b1;
        u_if.bso_rdy = 1'b1;
        for (int a = 0; a < 10; a++) begin
            logic [31:0] d;
            d = $urandom;
            exp_q.push_back({32'(a), d});
            bsi_write(32'(a), d);
        end
        begin
            int n;
            n = 0;
            while (rx_q.size() < 10 && n < 500) begin
                tick();
                n++;
            end
        end
        repeat (30) tick();
        check_val("lb_count", 64'(rx_q.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < rx_q.size()) check_val($sformatf("lb_pair%0d", i), rx_q[i], exp_q[i]);
            else check_val($sformatf("lb_missing%0d", i), 64'(rx_q.size()), 64'd10);
        end

`ifdef BUS_WRAP_CHECKSUM_EN
        // Corrupted frame is dropped, the following one is delivered
        rx_q.delete();
        corrupt_en_r = 1'b1;
        bsi_write(32'h0000_0020, 32'hDEAD_BEEF);
        repeat (30) tick();
        corrupt_en_r = 1'b0;
        check_val("cs_drop_cnt", 64'(rx_q.size()), 64'd0);
        check_val("cs_drop_vld", 64'(u_if.bso_vld), 64'd0);
        bsi_write(32'h0000_0021, 32'h1357_2468);
        repeat (30) tick();
        check_val("cs_good_cnt", 64'(rx_q.size()), 64'd1);
        if (rx_q.size() > 0) check_val("cs_good_pair", rx_q[0], {32'h0000_0021, 32'h1357_2468});
        else check_val("cs_good_missing", 64'(rx_q.size()), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end
endmodule

// File: doc/bus_wrap.md
Name: bus_wrap

Overview:
- Loopback-capable bus/stream bridge with two independent halves.
- Serializer: accepts one bus write (address + data) and emits it as a sequence of bytes on a valid/ready stream.
- Deserializer: collects bytes from a stream, reassembles them, and issues a bus write.
- Used as a link adapter. With sto_* looped back to sti_*, every bsi_* write reappears unchanged on bso_*.

Parameters:
- AW, 32, address width in bits; multiple of SW.
- DW, 32, data width in bits; multiple of SW.
- SW, 8, stream byte width.
- Derived: N = (AW+DW)/SW bytes per frame (8 by default).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-low (rst=0 resets).
- bsi_vld  input  1  input bus request valid.
- bsi_adr  input  AW  input bus address.
- bsi_dat  input  DW  input bus write data.
- bsi_rdy  output  1  input bus ready; transfer when bsi_vld & bsi_rdy.
- sto_vld  output  1  output stream byte valid.
- sto_bus  output  SW  output stream byte.
- sto_rdy  input  1  output stream ready.
- sti_vld  input  1  input stream byte valid.
- sti_bus  input  SW  input stream byte.
- sti_rdy  output  1  input stream ready.
- bso_vld  output  1  output bus request valid.
- bso_adr  output  AW  output bus address.
- bso_dat  output  DW  output bus data.
- bso_rdy  input  1  output bus ready; transfer when bso_vld & bso_rdy.

Behaviour:
- Reset (rst=0, asynchronous) clears all state. bsi_rdy=0, sto_vld=0, sto_bus=0, sti_rdy=0, bso_vld=0, bso_adr=0, bso_dat=0.
- Reset mid-frame discards partial frames on both halves.
- Serializer states: IDLE, SEND.
  - bsi_rdy=1 exactly in IDLE (registered; independent of bsi_vld).
  - On a bsi transfer: latch {bsi_dat,bsi_adr} into an (AW+DW)-bit shift register, set byte counter to N, go to SEND.
  - SEND: sto_vld=1 and sto_bus = current byte.
  - Byte order: address LSB byte first through address MSB byte, then data LSB byte through data MSB byte.
  - Each sto_vld & sto_rdy cycle shifts by SW and decrements the counter. After byte N is taken, return to IDLE.
  - sto_vld and sto_bus hold stable while sto_rdy=0.
  - Latency: first byte valid on the cycle after bsi acceptance.
  - Throughput: one frame per N+1 cycles with sto_rdy held at 1.
- Deserializer states: COLLECT, HOLD.
  - sti_rdy = (state==COLLECT), registered; 0 during reset.
  - Each sti_vld & sti_rdy shifts sti_bus into the assembly register, in the same byte order as the serializer.
  - After byte N: load bso_adr/bso_dat, set bso_vld=1 on the next edge, go to HOLD.
  - HOLD: outputs are stable until bso_vld & bso_rdy, then return to COLLECT with counter 0.
  - bso_adr and bso_dat keep their last value after the transfer.
- The two halves share no state; simultaneous activity on both is independent.
- Counters are log2(N+1) bits wide and never wrap. Address and data pass unmodified, with no arithmetic on them.

Optional Feature:
- Macro: BUS_WRAP_CHECKSUM_EN.
- Defined: the serializer appends byte N+1 = XOR of the N frame bytes.
  - The deserializer expects N+1 bytes and checks the XOR.
  - Match: bso_vld is raised as normal.
  - Mismatch: the frame is silently dropped; return to COLLECT with bso_vld untouched.
  - Throughput becomes one frame per N+2 cycles.
- Undefined: N-byte frames, no check byte, no checking logic.

Test Plan:
- Reset release: hold rst=0 for 4 cycles, then release → all outputs 0 during reset; bsi_rdy=1 and sti_rdy=1 on the first edge after release.
- Single frame: bsi_adr=0x00000003, bsi_dat=0x12345678, sto_rdy=1 → sto_bus sequence 03,00,00,00,78,56,34,12 on 8 consecutive cycles; bsi_rdy low during those cycles.
- Loopback burst: sto_* tied to sti_*, bso_rdy=1, addresses 0..9 with random data, each write issued when bsi_rdy=1 → exactly 10 bso transfers; bso_adr/bso_dat pairs match the inputs in order.
- Stream stall: sto_rdy=0 for 5 cycles in the middle of byte 4 → sto_vld=1 and sto_bus held; the remaining bytes resume with no loss or duplication.
- Output backpressure: bso_rdy=0 after a frame completes → bso_vld held, sti_rdy=0, upstream bytes not consumed; bso_rdy=1 → one transfer, then sti_rdy=1.
- Checksum (macro defined): corrupt byte 2 in the loop → no bso_vld for that frame; the next good frame is delivered correctly.
